tdm_demux21: RTL and testbench

- Receive-side partner of the team's 2:1 selector. A transmitter interleaves channel A (s=0) and channel B (s=1) samples onto one shared line; this block de-interleaves them.
- Each tagged sample is steered to its own registered output, and completed A/B pairs are re-assembled and presented together.
- Alternation errors are tracked with a small state machine and a pair counter.
- Sits between the shared TDM line and the two consumer channels.

---
 rtl/tdm_demux21.sv | 205 ++++++++++++++++++++
 tb/tb_tdm_demux21.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux21.sv
// rtl/tdm_demux21.sv - receive-side TDM 2:1 de-interleaver with A/B pair re-assembly
//
// Purpose:
//   Splits a shared line carrying channel A (s=0) and channel B (s=1)
//   samples into two registered outputs, re-assembles A-then-B pairs, and
//   flags alternation errors (orphan B, repeated A).
//
// Optional feature macro: TDM_DEMUX_ERRCNT_EN
//   When defined, adds ecnt (saturating err count) and sticky_err.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   d          in   [WIDTH-1:0] shared-line sample
//   dv         in   d/s valid this cycle
//   s          in   channel tag, 0 = A, 1 = B
//   ya, yb     out  [WIDTH-1:0] last A / B sample
//   va, vb     out  1-cycle strobes: ya / yb updated
//   pa, pb     out  [WIDTH-1:0] paired A / B sample
//   pv         out  1-cycle strobe: pa/pb hold a complete pair
//   err        out  1-cycle strobe: alternation violation
//   pcnt       out  [CNT_W-1:0] completed-pair count, saturating
//   ecnt       out  [CNT_W-1:0] err strobe count, saturating (macro only)
//   sticky_err out  set by any err, cleared by rst (macro only)

module tdm_demux21 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             dv,
  input  logic             s,
  output logic [WIDTH-1:0] ya,
  output logic [WIDTH-1:0] yb,
  output logic             va,
  output logic             vb,
  output logic [WIDTH-1:0] pa,
  output logic [WIDTH-1:0] pb,
  output logic             pv,
  output logic             err,
  output logic [CNT_W-1:0] pcnt
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] ecnt,
  output logic             sticky_err
`endif
);

  typedef enum logic {
    EXP_A = 1'b0,
    EXP_B = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] held_a;

  // Decoded sample kinds for this cycle.
  logic take_a;
  logic take_b;
  assign take_a = dv & ~s;
  assign take_b = dv & s;

  // Next-cycle values of the registered outputs.
  logic [WIDTH-1:0] ya_nxt;
  logic [WIDTH-1:0] yb_nxt;
  logic [WIDTH-1:0] pa_nxt;
  logic [WIDTH-1:0] pb_nxt;
  logic             va_nxt;
  logic             vb_nxt;
  logic             pv_nxt;
  logic             err_nxt;
  logic [CNT_W-1:0] pcnt_nxt;

  // ---------------------------------------------------------------------------
  // State register (plus the held A sample that belongs to EXP_B)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EXP_A;
      held_a <= '0;
    end else begin
      state <= state_nxt;
      // A repeated A simply replaces the held one, so every A is captured.
      if (take_a) begin
        held_a <= d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      EXP_A: begin
        if (take_a) begin
          state_nxt = EXP_B;
        end
      end
      EXP_B: begin
        if (take_b) begin
          state_nxt = EXP_A;
        end
      end
      default: state_nxt = EXP_A;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (computes what the output registers load next)
  // ---------------------------------------------------------------------------
  always_comb begin
    ya_nxt   = ya;
    yb_nxt   = yb;
    pa_nxt   = pa;
    pb_nxt   = pb;
    va_nxt   = 1'b0;
    vb_nxt   = 1'b0;
    pv_nxt   = 1'b0;
    err_nxt  = 1'b0;
    pcnt_nxt = pcnt;

    // Steering does not depend on the FSM: every tagged sample lands on
    // its own channel output, even when it also raises err.
    if (take_a) begin
      ya_nxt = d;
      va_nxt = 1'b1;
    end
    if (take_b) begin
      yb_nxt = d;
      vb_nxt = 1'b1;
    end

    case (state)
      EXP_A: begin
        if (take_b) begin
          err_nxt = 1'b1;
        end
      end
      EXP_B: begin
        if (take_b) begin
          pa_nxt = held_a;
          pb_nxt = d;
          pv_nxt = 1'b1;
          if (!(&pcnt)) begin
            pcnt_nxt = pcnt + CNT_W'(1);
          end
        end else if (take_a) begin
          err_nxt = 1'b1;
        end
      end
      default: begin
        err_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ya   <= '0;
      yb   <= '0;
      pa   <= '0;
      pb   <= '0;
      va   <= 1'b0;
      vb   <= 1'b0;
      pv   <= 1'b0;
      err  <= 1'b0;
      pcnt <= '0;
    end else begin
      ya   <= ya_nxt;
      yb   <= yb_nxt;
      pa   <= pa_nxt;
      pb   <= pb_nxt;
      va   <= va_nxt;
      vb   <= vb_nxt;
      pv   <= pv_nxt;
      err  <= err_nxt;
      pcnt <= pcnt_nxt;
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  // Error accounting tracks err_nxt so ecnt/sticky_err move in the same
  // cycle as the err strobe they account for.
  always_ff @(posedge clk) begin
    if (rst) begin
      ecnt       <= '0;
      sticky_err <= 1'b0;
    end else if (err_nxt) begin
      sticky_err <= 1'b1;
      if (!(&ecnt)) begin
        ecnt <= ecnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux21.sv
// tb/tb_tdm_demux21.sv - self-checking bench for tdm_demux21

module tb_tdm_demux21;

  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int PMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  d   = '0;
  logic          dv  = 1'b0;
  logic          s   = 1'b0;
  logic [W-1:0]  ya, yb, pa, pb;
  logic          va, vb, pv, err;
  logic [CW-1:0] pcnt;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [CW-1:0] ecnt;
  logic          sticky_err;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  tdm_demux21 #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .dv  (dv),
    .s   (s),
    .ya  (ya),
    .yb  (yb),
    .va  (va),
    .vb  (vb),
    .pa  (pa),
    .pb  (pb),
    .pv  (pv),
    .err (err),
    .pcnt(pcnt)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .ecnt      (ecnt),
    .sticky_err(sticky_err)
`endif
  );

  // Behavioural model: a queue holds the pending A sample (0 or 1 entries);
  // counts are kept as unbounded ints and clamped when compared.
  logic [W-1:0] pend_q[$];
  logic [W-1:0] m_ya, m_yb, m_pa, m_pb;
  logic         m_va, m_vb, m_pv, m_err, m_sticky;
  int           m_pairs, m_errs;
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ya = '0; m_yb = '0; m_pa = '0; m_pb = '0;
      m_va = 0; m_vb = 0; m_pv = 0; m_err = 0; m_sticky = 0;
      m_pairs = 0; m_errs = 0;
      pend_q.delete();
      m_valid = 1'b1;
    end else begin
      m_va = 0; m_vb = 0; m_pv = 0; m_err = 0;
      if (dv && !s) begin
        m_ya = d;
        m_va = 1;
        if (pend_q.size() != 0) begin
          m_err = 1;
          pend_q.delete();
        end
        pend_q.push_back(d);
      end else if (dv && s) begin
        m_yb = d;
        m_vb = 1;
        if (pend_q.size() == 0) begin
          m_err = 1;
        end else begin
          m_pa = pend_q.pop_front();
          m_pb = d;
          m_pv = 1;
          m_pairs++;
        end
      end
      if (m_err) begin
        m_errs++;
        m_sticky = 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("ya", 32'(ya), 32'(m_ya));
      check("yb", 32'(yb), 32'(m_yb));
      check("va", 32'(va), 32'(m_va));
      check("vb", 32'(vb), 32'(m_vb));
      check("pa", 32'(pa), 32'(m_pa));
      check("pb", 32'(pb), 32'(m_pb));
      check("pv", 32'(pv), 32'(m_pv));
      check("err", 32'(err), 32'(m_err));
      check("pcnt", 32'(pcnt), 32'((m_pairs > PMAX) ? PMAX : m_pairs));
      check("pv_err_excl", 32'(pv & err), 32'(0));
`ifdef TDM_DEMUX_ERRCNT_EN
      check("ecnt", 32'(ecnt), 32'((m_errs > PMAX) ? PMAX : m_errs));
      check("sticky_err", 32'(sticky_err), 32'(m_sticky));
`endif
    end
  end

  // Drive one cycle of inputs; they are sampled at the next rising edge.
  task automatic cyc(input logic r, input logic v, input logic ss, input logic [W-1:0] dd);
    @(negedge clk);
    rst = r; dv = v; s = ss; d = dd;
  endtask

  // Wait for the edge that samples the last cyc() and look just after it.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    // Reset with busy inputs held on the line.
    cyc(1'b1, 1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, 1'b1, 8'hFF);
    settle();
    check("rst_yb", 32'(yb), 32'h0);
    check("rst_vb", 32'(vb), 32'h0);
    check("rst_pcnt", 32'(pcnt), 32'h0);

    // First pair after reset.
    cyc(1'b0, 1'b1, 1'b0, 8'h05);
    cyc(1'b0, 1'b1, 1'b1, 8'h06);
    settle();
    check("first_pv", 32'(pv), 32'h1);
    check("first_pcnt", 32'(pcnt), 32'h1);

    // Alternating back-to-back stream.
    cyc(1'b0, 1'b1, 1'b0, 8'h11);
    cyc(1'b0, 1'b1, 1'b1, 8'h22);
    settle();
    check("alt1_pa", 32'(pa), 32'h11);
    check("alt1_pb", 32'(pb), 32'h22);
    cyc(1'b0, 1'b1, 1'b0, 8'h33);
    cyc(1'b0, 1'b1, 1'b1, 8'h44);
    settle();
    check("alt2_pa", 32'(pa), 32'h33);
    check("alt2_pb", 32'(pb), 32'h44);
    check("alt2_pcnt", 32'(pcnt), 32'h3);
    idle(1);

    // Orphan B, then a clean pair.
    cyc(1'b0, 1'b1, 1'b1, 8'h5A);
    settle();
    check("orphan_err", 32'(err), 32'h1);
    check("orphan_yb", 32'(yb), 32'h5A);
    check("orphan_pv", 32'(pv), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'h01);
    cyc(1'b0, 1'b1, 1'b1, 8'h02);
    settle();
    check("after_orphan_pa", 32'(pa), 32'h01);
    check("after_orphan_pb", 32'(pb), 32'h02);

    // Repeated A.
    cyc(1'b0, 1'b1, 1'b0, 8'hAA);
    cyc(1'b0, 1'b1, 1'b0, 8'hBB);
    settle();
    check("rep_err", 32'(err), 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 8'hCC);
    settle();
    check("rep_pa", 32'(pa), 32'hBB);
    check("rep_pb", 32'(pb), 32'hCC);
    check("rep_pcnt", 32'(pcnt), 32'h5);

    // Gap between A and B.
    cyc(1'b0, 1'b1, 1'b0, 8'h10);
    idle(5);
    cyc(1'b0, 1'b1, 1'b1, 8'h20);
    settle();
    check("gap_pa", 32'(pa), 32'h10);
    check("gap_pb", 32'(pb), 32'h20);

    // Reset inside a gap discards the held A.
    cyc(1'b0, 1'b1, 1'b0, 8'h77);
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    idle(1);
    cyc(1'b0, 1'b1, 1'b1, 8'h88);
    settle();
    check("rstgap_err", 32'(err), 32'h1);
    check("rstgap_pv", 32'(pv), 32'h0);

    // Run pcnt past saturation.
    for (int i = 0; i < PMAX + 2; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'(i));
      cyc(1'b0, 1'b1, 1'b1, 8'(i + 8'h40));
    end
    settle();
    check("sat_pcnt", 32'(pcnt), 32'(PMAX));
    check("sat_pv", 32'(pv), 32'h1);
    idle(1);

`ifdef TDM_DEMUX_ERRCNT_EN
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 8'h90);
    settle();
    check("ecnt3", 32'(ecnt), 32'h3);
    check("sticky_set", 32'(sticky_err), 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 8'h01);
    cyc(1'b0, 1'b1, 1'b1, 8'h02);
    idle(2);
    settle();
    check("sticky_hold", 32'(sticky_err), 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    check("sticky_clr", 32'(sticky_err), 32'h0);
    idle(1);
`endif

    idle(2);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
